// File: rtl/gemm_tile_sequencer.sv
// gemm_tile_sequencer: splits an MxK by KxN GEMM job into TILE_K x TILE_N tiles, N-outer K-inner
module gemm_tile_sequencer #(
    parameter int DIM_W  = 12,
    parameter int TILE_K = 16,
    parameter int TILE_N = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DIM_W-1:0] cmd_m,
    input  logic [DIM_W-1:0] cmd_n,
    input  logic [DIM_W-1:0] cmd_k,
    output logic             tile_valid,
    input  logic             tile_ready,
    output logic [4:0]       ksize,
    output logic [4:0]       nsize,
    output logic [DIM_W-1:0] msize,
    output logic [DIM_W-1:0] k_base,
    output logic [DIM_W-1:0] n_base,
    output logic             first_k,
    output logic             last_k,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    localparam logic [DIM_W:0] LP_TK = (DIM_W+1)'(TILE_K);
    localparam logic [DIM_W:0] LP_TN = (DIM_W+1)'(TILE_N);
    state_t           r_state;
    logic [DIM_W-1:0] r_m, r_n, r_k, r_kb, r_nb;
    logic             r_err;
    logic             w_issue, w_lk, w_ln;
    logic [4:0]       w_krem, w_nrem;
    // last-tile tests in DIM_W+1 bits so base + tile extent cannot wrap
    always_comb begin
        w_issue = r_state == ISSUE;
        w_lk    = ({1'b0, r_kb} + LP_TK) >= {1'b0, r_k};
        w_ln    = ({1'b0, r_nb} + LP_TN) >= {1'b0, r_n};
        w_krem  = 5'(r_k - r_kb);
        w_nrem  = 5'(r_n - r_nb);
    end
    // tile descriptor from registers only, zeroed outside ISSUE
    always_comb begin
        cmd_ready  = r_state == IDLE;
        busy       = r_state != IDLE;
        done       = r_state == DONE;
        err        = r_err;
        tile_valid = w_issue;
        ksize      = w_issue ? (w_lk ? w_krem : 5'(TILE_K)) : 5'd0;
        nsize      = w_issue ? (w_ln ? w_nrem : 5'(TILE_N)) : 5'd0;
        msize      = w_issue ? r_m : '0;
        k_base     = w_issue ? r_kb : '0;
        n_base     = w_issue ? r_nb : '0;
        first_k    = w_issue && (r_kb == '0);
        last_k     = w_issue && w_lk;
    end
    // job acceptance, tile stepping and done/err sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_m     <= '0;
            r_n     <= '0;
            r_k     <= '0;
            r_kb    <= '0;
            r_nb    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: if (cmd_valid) begin
                    if (cmd_m == '0 || cmd_n == '0 || cmd_k == '0) r_err <= 1'b1;
                    else begin
                        r_m     <= cmd_m;
                        r_n     <= cmd_n;
                        r_k     <= cmd_k;
                        r_kb    <= '0;
                        r_nb    <= '0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: if (tile_ready) begin
                    if (w_lk && w_ln) r_state <= DONE;
                    else if (w_lk) begin
                        r_kb <= '0;
                        r_nb <= r_nb + DIM_W'(TILE_N);
                    end else r_kb <= r_kb + DIM_W'(TILE_K);
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// tb_gemm_tile_sequencer: directed table-driven bench for the GEMM tile sequencer
module tb_gemm_tile_sequencer;
    logic        clk, rst, cmd_valid, cmd_ready, tile_valid, tile_ready;
    logic [11:0] cmd_m, cmd_n, cmd_k, msize, k_base, n_base;
    logic [4:0]  ksize, nsize;
    logic        first_k, last_k, busy, done, err;
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        int kb, nb, ks, ns;
        bit fk, lk;
    } tile_t;
    tile_t tbl[6];
    tile_t t_one;

    gemm_tile_sequencer #(.DIM_W(12), .TILE_K(16), .TILE_N(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_k(cmd_k),
        .tile_valid(tile_valid), .tile_ready(tile_ready),
        .ksize(ksize), .nsize(nsize), .msize(msize),
        .k_base(k_base), .n_base(n_base),
        .first_k(first_k), .last_k(last_k),
        .busy(busy), .done(done), .err(err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_tile(input string nm, input tile_t t, input int m);
        chk({nm, " tile_valid"}, 32'(tile_valid), 1);
        chk({nm, " cmd_ready"}, 32'(cmd_ready), 0);
        chk({nm, " busy"}, 32'(busy), 1);
        chk({nm, " k_base"}, 32'(k_base), t.kb);
        chk({nm, " n_base"}, 32'(n_base), t.nb);
        chk({nm, " ksize"}, 32'(ksize), t.ks);
        chk({nm, " nsize"}, 32'(nsize), t.ns);
        chk({nm, " first_k"}, 32'(first_k), 32'(t.fk));
        chk({nm, " last_k"}, 32'(last_k), 32'(t.lk));
        chk({nm, " msize"}, 32'(msize), m);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " cmd_ready"}, 32'(cmd_ready), 1);
        chk({nm, " tile_valid"}, 32'(tile_valid), 0);
        chk({nm, " busy"}, 32'(busy), 0);
        chk({nm, " done"}, 32'(done), 0);
        chk({nm, " err"}, 32'(err), 0);
        chk({nm, " fields"}, 32'({ksize, nsize, msize, k_base, n_base, first_k, last_k} != '0), 0);
    endtask

    task automatic send(input int m, input int n, input int k);
        cmd_valid = 1;
        cmd_m = 12'(m);
        cmd_n = 12'(n);
        cmd_k = 12'(k);
        @(posedge clk);
        #1 cmd_valid = 0;
        @(negedge clk);
    endtask

    task automatic chk_done(input string nm);
        chk({nm, " done"}, 32'(done), 1);
        chk({nm, " tile_valid"}, 32'(tile_valid), 0);
        chk({nm, " cmd_ready in DONE"}, 32'(cmd_ready), 0);
        @(negedge clk);
        chk({nm, " done drop"}, 32'(done), 0);
        chk({nm, " cmd_ready back"}, 32'(cmd_ready), 1);
    endtask

    initial begin
        tbl[0] = '{0, 0, 16, 16, 1, 0};
        tbl[1] = '{16, 0, 16, 16, 0, 0};
        tbl[2] = '{32, 0, 8, 16, 0, 1};
        tbl[3] = '{0, 16, 16, 4, 1, 0};
        tbl[4] = '{16, 16, 16, 4, 0, 0};
        tbl[5] = '{32, 16, 8, 4, 0, 1};
        rst = 1;
        tile_ready = 1;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'($urandom);
            cmd_m = 12'($urandom);
            cmd_n = 12'($urandom);
            cmd_k = 12'($urandom);
            tile_ready = 1'($urandom);
            @(negedge clk);
            chk_idle("reset");
        end
        cmd_valid = 0;
        tile_ready = 1;
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            chk_idle("post-reset");
        end

        send(7, 20, 40);
        for (int i = 0; i < 6; i++) begin
            chk_tile($sformatf("seq t%0d", i + 1), tbl[i], 7);
            @(negedge clk);
        end
        chk_done("seq");

        send(7, 20, 40);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                tile_ready = 0;
                repeat (4) begin
                    chk_tile("stall t2", tbl[1], 7);
                    @(negedge clk);
                end
                tile_ready = 1;
            end
            chk_tile($sformatf("bp t%0d", i + 1), tbl[i], 7);
            @(negedge clk);
        end
        chk_done("bp");

        t_one = '{0, 0, 5, 3, 1, 1};
        send(1, 3, 5);
        chk_tile("small", t_one, 1);
        @(negedge clk);
        chk_done("small");

        send(4, 4, 0);
        chk("zero err", 32'(err), 1);
        chk("zero cmd_ready", 32'(cmd_ready), 1);
        chk("zero tile_valid", 32'(tile_valid), 0);
        chk("zero busy", 32'(busy), 0);
        t_one = '{0, 0, 16, 16, 1, 1};
        send(3, 16, 16);
        chk("err pulse width", 32'(err), 0);
        chk_tile("after err", t_one, 3);
        @(negedge clk);
        chk_done("after err");

        send(7, 20, 40);
        chk_tile("pre-rst t1", tbl[0], 7);
        @(negedge clk);
        chk_tile("pre-rst t2", tbl[1], 7);
        @(negedge clk);
        chk_tile("pre-rst t3", tbl[2], 7);
        #1 rst = 1;
        #1 chk_idle("async rst");
        @(negedge clk);
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            chk_idle("abandoned");
        end
        send(2, 16, 16);
        chk_tile("fresh", t_one, 2);
        @(negedge clk);
        chk_done("fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gemm_tile_sequencer.md
# gemm_tile_sequencer

Upstream control stage of the systolic datapath. Accepts one GEMM job (M×K by K×N) per command and splits it into tiles no larger than `TILE_K`×`TILE_N`. Issues the tiles one at a time over a valid/ready handshake, carrying the per-tile `ksize`/`nsize` consumed by the mode decoder plus accumulation and position markers. Iteration is N-outer, K-inner, so partial sums for one output column block complete before the next block starts.

## Interface

Parameters:
- `DIM_W`, 12, width of job dimensions and tile base offsets.
- `TILE_K`, 16, maximum tile K extent; must be in 1..31 to fit `ksize`.
- `TILE_N`, 16, maximum tile N extent; must be in 1..31 to fit `nsize`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high. The clock port is `clk` and the reset port is `rst`.
- `clk` input 1 — clock; all state updates on the rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `cmd_valid` input 1 — job command present.
- `cmd_ready` output 1 — sequencer can accept a job.
- `cmd_m`, `cmd_n`, `cmd_k` input DIM_W each — job dimensions.
- `tile_valid` output 1 — tile descriptor valid.
- `tile_ready` input 1 — downstream accepts the tile.
- `ksize` output 5 — rows of the current tile along K.
- `nsize` output 5 — columns of the current tile along N.
- `msize` output DIM_W — latched M, streamed unchanged per tile.
- `k_base`, `n_base` output DIM_W each — tile origin offsets.
- `first_k` output 1 — first K tile of the current N block (clear accumulator).
- `last_k` output 1 — last K tile of the current N block (write back).
- `busy` output 1 — state is not IDLE.
- `done` output 1 — one-cycle pulse after the last tile handshake.
- `err` output 1 — one-cycle pulse for a rejected zero-dimension job.

## Operation

- States: IDLE, ISSUE, DONE.
- IDLE:
  - `cmd_ready` = 1.
  - On `cmd_valid` with any dimension equal to 0: job dropped, `err` = 1 on the next cycle, state stays IDLE.
  - On `cmd_valid` otherwise: latch M/N/K, clear `k_base` and `n_base` to 0, go to ISSUE.
- ISSUE:
  - `tile_valid` = 1; `cmd_ready` = 0.
  - `ksize` = min(TILE_K, K − k_base); `nsize` = min(TILE_N, N − n_base).
  - `first_k` = (k_base == 0); `last_k` = (k_base + TILE_K ≥ K).
  - All tile outputs are held stable while `tile_ready` = 0.
- Handshake (`tile_valid` && `tile_ready`):
  - If `last_k` and n_base + TILE_N ≥ N: go to DONE.
  - Else if `last_k`: k_base ← 0, n_base ← n_base + TILE_N.
  - Else: k_base ← k_base + TILE_K.
- DONE: `done` = 1 for one cycle, `cmd_ready` = 0, then IDLE.
- Tile count = ceil(K/TILE_K) × ceil(N/TILE_N).
- Arithmetic:
  - Comparisons use DIM_W+1 bits so base + TILE never wraps.
  - `ksize` and `nsize` are never 0 in ISSUE.
- Tile outputs are driven from registers and latched dimensions only. There is no combinational path from `tile_ready` or `cmd_valid` to any output.
- When `tile_valid` = 0, tile fields are 0.

## Timing

- Reset values:
  - state IDLE; `cmd_ready` = 1 (from IDLE).
  - `tile_valid`, `done`, `err`, `busy` = 0.
  - `ksize`, `nsize`, `msize`, `k_base`, `n_base`, `first_k`, `last_k` = 0.
- Command accepted at edge t: `tile_valid` = 1 and `busy` = 1 from cycle t+1.
- Sustained `tile_ready` = 1: one tile per cycle, no bubbles between tiles.
- Last tile handshake at edge t: `done` = 1 in cycle t+1, `cmd_ready` = 1 in cycle t+2.
- Zero-dimension command at edge t: `err` = 1 in cycle t+1; `cmd_ready` stays 1 throughout.
- `rst` asserted mid-job: all outputs reach reset values immediately (asynchronous). The in-flight job is abandoned, no `done` is produced, and the next command starts fresh.
- `cmd_valid` while busy: ignored and not latched, because `cmd_ready` = 0.

## Test plan

- Reset: assert `rst` with random inputs → all outputs at reset values and `cmd_ready` = 1; deassert → no `tile_valid` without a command.
- M=7, K=40, N=20, `tile_ready` = 1 → 6 consecutive tiles (k_base, n_base, ksize, nsize):
  - (0,0,16,16), (16,0,16,16), (32,0,8,16), (0,16,16,4), (16,16,16,4), (32,16,8,4).
  - `first_k` on tiles 1 and 4, `last_k` on tiles 3 and 6, `msize` = 7.
  - `done` one cycle after tile 6.
- K=5, N=3, M=1 → single tile with ksize=5, nsize=3, `first_k` = `last_k` = 1; `done` 2 cycles after the command, `cmd_ready` back high 3 cycles after.
- Backpressure: hold `tile_ready` = 0 for 4 cycles on tile 2 of the K=40/N=20 job → descriptor unchanged during the stall, sequence and tile count unchanged overall.
- `cmd_k` = 0 → `err` pulse exactly one cycle, no `tile_valid`, state stays IDLE; a valid command sent immediately after is accepted normally.
- `rst` during tile 3 of the K=40/N=20 job → outputs cleared, no `done`; a new K=16, N=16 job then yields one tile (16,16).
